// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch front end.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [63:0] INSTR_BYTES = 64'd4;
    localparam logic [63:0] ALIGN_MASK  = 64'h3;

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
// Module      : fetch_queue
// Description : In-order FIFO of fetch entries with flush; push and pop may
//               coincide at full. Head reads as zero when empty.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  fetch_entry_t             i_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output fetch_entry_t             o_head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] c_full_count = CW'(DEPTH);

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_pop;
    logic            w_push;

    assign w_pop  = i_pop & ~i_flush & (r_count != '0);
    assign w_push = i_push & ~i_flush & ((r_count != c_full_count) | w_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module      : instruction_fetch
// Description : Fetch front end: drives imem, queues {pc, instr} toward decode,
//               handles redirects. Optional macro IFETCH_ALIGN_CHECK_EN makes
//               misaligned redirects trap into a FAULT state.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module instruction_fetch
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_adr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault,
    output logic [63:0] fault_pc
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] c_full_count = CW'(QUEUE_DEPTH);

    logic [63:0]   r_fetch_pc;
    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    fetch_state_t  w_state;
    logic          w_pop;
    logic          w_push;

    assign w_pop   = out_valid & out_ready;
    assign w_push  = (w_state == FETCH) & ~redirect_valid
                   & ((w_count != c_full_count) | w_pop);
    assign w_entry = '{pc: r_fetch_pc, instr: imem_instr};

`ifdef IFETCH_ALIGN_CHECK_EN
    fetch_state_t r_state;
    logic         r_fault;
    logic [63:0]  r_fault_pc;
    logic         w_misaligned;

    assign w_misaligned = |(redirect_pc & ALIGN_MASK);

    // A misaligned redirect still flushes the queue but leaves the PC frozen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= FETCH;
            r_fetch_pc <= RESET_PC;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
        end else if (redirect_valid) begin
            if (w_misaligned) begin
                r_state    <= FAULT;
                r_fault    <= 1'b1;
                r_fault_pc <= redirect_pc;
            end else begin
                r_state    <= FETCH;
                r_fault    <= 1'b0;
                r_fetch_pc <= redirect_pc;
            end
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
        end
    end

    assign w_state  = r_state;
    assign fault    = r_fault;
    assign fault_pc = r_fault_pc;
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc & ~ALIGN_MASK;
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + INSTR_BYTES;
        end
    end

    assign w_state  = FETCH;
    assign fault    = 1'b0;
    assign fault_pc = '0;
`endif

    fetch_queue #(
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign imem_adr  = r_fetch_pc;
    assign out_valid = (w_count != '0);
    assign out_instr = w_head.instr;
    assign out_pc    = w_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Randomized self-checking bench for instruction_fetch with a
//               queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;

    localparam int DEPTH = 2;
`ifdef IFETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } ment_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] imem_adr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [63:0] fault_pc;

    logic [63:0] w2_adr;
    logic [31:0] w2_imem;
    logic        w2_valid;
    logic [31:0] w2_instr;
    logic [63:0] w2_pc;
    logic        w2_fault;
    logic [63:0] w2_fault_pc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [63:0] m_pc;
    ment_t       m_q[$];
    logic        m_fault;
    logic [63:0] m_fault_pc;
    bit          m_trap;

    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [63:0] a);
        return 32'hA000_0000 + a[33:2];
    endfunction

    assign imem_instr = memw(imem_adr);
    assign w2_imem    = memw(w2_adr);

    instruction_fetch #(.RESET_PC(64'h0), .QUEUE_DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset(rst), .imem_adr(imem_adr), .imem_instr(imem_instr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .fault(fault), .fault_pc(fault_pc)
    );

    instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .QUEUE_DEPTH(DEPTH)) u_wrap (
        .clk(clk), .reset(rst), .imem_adr(w2_adr), .imem_instr(w2_imem),
        .redirect_valid(1'b0), .redirect_pc(64'h0),
        .out_valid(w2_valid), .out_ready(1'b1), .out_instr(w2_instr),
        .out_pc(w2_pc), .fault(w2_fault), .fault_pc(w2_fault_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_pc       = 64'h0;
        m_q.delete();
        m_fault    = 1'b0;
        m_fault_pc = '0;
        m_trap     = 1'b0;
    endtask

    task automatic m_step(input bit rdy, input bit rv, input logic [63:0] rpc);
        int sz;
        bit pop;
        sz  = m_q.size();
        pop = (sz != 0) && rdy;
        if (rv) begin
            m_q.delete();
            if (ALIGN_EN && (rpc[1:0] != 2'b00)) begin
                m_trap     = 1'b1;
                m_fault    = 1'b1;
                m_fault_pc = rpc;
            end else begin
                m_trap  = 1'b0;
                m_fault = 1'b0;
                m_pc    = {rpc[63:2], 2'b00};
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (!m_trap && (sz < DEPTH || pop)) begin
                m_q.push_back('{pc: m_pc, instr: memw(m_pc)});
                m_pc = m_pc + 64'd4;
            end
        end
    endtask

    task automatic cyc(input bit rdy, input bit rv, input logic [63:0] rpc);
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        m_step(rdy, rv, rpc);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", {63'b0, out_valid}, {63'b0, m_q.size() != 0});
            check("out_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 64'h0);
            check("out_instr", {32'b0, out_instr}, {32'b0, (m_q.size() != 0) ? m_q[0].instr : 32'h0});
            check("imem_adr", imem_adr, m_pc);
            check("fault", {63'b0, fault}, {63'b0, m_fault});
            check("fault_pc", fault_pc, m_fault_pc);
        end
    end

    initial begin
        logic [63:0] rp;
        bit          rdy;
        bit          rv;

        m_reset();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_adr", imem_adr, 64'h0);
        check("rst_valid", {63'b0, out_valid}, 64'h0);
        check("rst_pc", out_pc, 64'h0);
        check("rst_fault", {63'b0, fault}, 64'h0);
        check("rst_wrap_adr", w2_adr, 64'hFFFF_FFFF_FFFF_FFFC);
        rst = 1'b0;

        // Streaming from reset, plus the wrapping instance.
        cyc(1, 0, 0);
        check("s0_pc", out_pc, 64'h0);
        check("s0_instr", {32'b0, out_instr}, 64'hA000_0000);
        check("wrap0_pc", w2_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc(1, 0, 0);
        check("s1_pc", out_pc, 64'h4);
        check("s1_instr", {32'b0, out_instr}, 64'hA000_0001);
        check("wrap1_pc", w2_pc, 64'h0);
        cyc(1, 0, 0);
        check("s2_pc", out_pc, 64'h8);
        check("wrap2_pc", w2_pc, 64'h4);

        // Backpressure with head at PC 8.
        repeat (4) cyc(0, 0, 0);
        check("bp_pc", out_pc, 64'h8);
        check("bp_adr", imem_adr, 64'h10);
        cyc(1, 0, 0);
        check("bp_rel1", out_pc, 64'hC);
        cyc(1, 0, 0);
        check("bp_rel2", out_pc, 64'h10);

        // Redirect while full.
        cyc(0, 0, 0);
        cyc(1, 1, 64'h20);
        check("rd_valid", {63'b0, out_valid}, 64'h0);
        check("rd_adr", imem_adr, 64'h20);
        cyc(1, 0, 0);
        check("rd_pc0", out_pc, 64'h20);
        cyc(1, 0, 0);
        check("rd_pc1", out_pc, 64'h24);

        // Misaligned redirect.
        cyc(1, 1, 64'h22);
        check("mis_valid", {63'b0, out_valid}, 64'h0);
`ifdef IFETCH_ALIGN_CHECK_EN
        check("mis_fault", {63'b0, fault}, 64'h1);
        check("mis_fault_pc", fault_pc, 64'h22);
        check("mis_adr", imem_adr, 64'h28);
        repeat (2) cyc(1, 0, 0);
        check("mis_hold_adr", imem_adr, 64'h28);
        check("mis_hold_valid", {63'b0, out_valid}, 64'h0);
        cyc(1, 1, 64'h40);
        check("mis_clear", {63'b0, fault}, 64'h0);
        cyc(1, 0, 0);
        check("mis_resume_pc", out_pc, 64'h40);
`else
        check("mis_adr", imem_adr, 64'h20);
        cyc(1, 0, 0);
        check("mis_aligned_pc", out_pc, 64'h20);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       rp = {$urandom, $urandom};
                1:       rp = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: rp = 64'($urandom_range(0, 255));
            endcase
            cyc(rdy, rv, rp);
        end

        // Asynchronous reset with a valid head stalled.
        cyc(1, 1, 64'h100);
        repeat (2) cyc(0, 0, 0);
        check("ar_pre_valid", {63'b0, out_valid}, 64'h1);
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        check("ar_valid", {63'b0, out_valid}, 64'h0);
        check("ar_adr", imem_adr, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 0, 0);
        check("ar_pc0", out_pc, 64'h0);
        cyc(1, 0, 0);
        check("ar_pc1", out_pc, 64'h4);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch front end that drives the instruction memory's combinational read port and streams 32-bit instructions with their PCs to decode over a valid/ready handshake. Holds the fetch PC, advances it by 4 per accepted fetch, and absorbs decode backpressure in a small in-order queue. Handles control-flow redirects from execute by flushing and refetching. Sits between the instruction memory and the decode stage of the 64-bit core.

## Interface
- RESET_PC, 64'h0, fetch PC loaded on reset.
- QUEUE_DEPTH, 2, entries in the fetch queue; power of two, ≥2.
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high.
- imem_adr  out  64  byte address to instruction memory; equals fetch PC register.
- imem_instr  in  32  instruction at imem_adr, valid combinationally in the same cycle.
- redirect_valid  in  1  one-cycle pulse: discard queue, restart fetch at redirect_pc.
- redirect_pc  in  64  redirect target, byte address.
- out_valid  out  1  queue head is valid.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  32  head instruction.
- out_pc  out  64  head PC.
- fault  out  1  misaligned redirect taken (IFETCH_ALIGN_CHECK_EN only; tied 0 otherwise).
- fault_pc  out  64  offending redirect_pc (IFETCH_ALIGN_CHECK_EN only; tied 0 otherwise).

## Operation
- State machine in fetch_state_t: FETCH, FAULT. Reset enters FETCH.
- pop = out_valid & out_ready.
- push = (state==FETCH) & ~redirect_valid & (count<QUEUE_DEPTH | pop).
- On push: enqueue {fetch_pc, imem_instr}; fetch_pc <= fetch_pc + 4, modulo 2^64, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
- Push and pop in the same cycle at full are allowed. Count is unchanged and no entry is lost.
- Queue is in-order. The head is driven on out_instr/out_pc; out_valid = (count!=0).
- Empty queue: out_instr and out_pc drive 0.
- Redirect wins over everything in its cycle:
  - queue flushed (count <= 0), including any entry popped that cycle;
  - fetch_pc <= redirect_pc;
  - no push.
- The pop handshake in the redirect cycle is still honoured by decode; fetch ignores it.
- Redirect with redirect_pc[1:0]!=0:
  - With IFETCH_ALIGN_CHECK_EN: go to FAULT; fault <= 1; fault_pc <= redirect_pc.
  - Without the macro: redirect_pc[1:0] is forced to 2'b00 and fetch continues.
- FAULT:
  - no pushes; imem_adr holds;
  - an aligned redirect returns to FETCH, clears fault, and loads fetch_pc;
  - a misaligned redirect stays in FAULT and updates fault_pc.
- Reset mid-operation: queue and state cleared immediately, regardless of handshake in flight.

## Timing
- Reset values:
  - fetch_pc/imem_adr = RESET_PC;
  - out_valid = 0, out_instr = 0, out_pc = 0;
  - fault = 0, fault_pc = 0;
  - count = 0, state = FETCH.
- Latency is one cycle, address to output. Instruction read at imem_adr in cycle N appears at the queue head in N+1 if the queue was empty.
- Throughput: one instruction per cycle with out_ready held high.
- Redirect in cycle N:
  - out_valid = 0 in N+1;
  - imem_adr = redirect_pc in N+1;
  - first redirected instruction valid in N+2.
- Backpressure: after out_ready falls, at most QUEUE_DEPTH entries buffer, then imem_adr holds. Fetch resumes the cycle out_ready rises again, with no bubble at full.
- All outputs are registered except out_valid, which derives from registered count.

## Configuration
- IFETCH_ALIGN_CHECK_EN:
  - Defined: FAULT state, fault and fault_pc are implemented, and misaligned redirects trap.
  - Undefined: FAULT state is absent, fault and fault_pc are constant 0, and redirect targets are silently word-aligned.

## Structure
- Package fetch_pkg:
  - fetch_state_t enum (FETCH, FAULT);
  - fetch_entry_t packed struct {pc[63:0], instr[31:0]};
  - INSTR_BYTES = 4;
  - ALIGN_MASK = 64'h3.
- One sub-module, fetch_queue: parameterised FIFO of fetch_entry_t with push, pop, flush, count, head. It wraps read/write pointers modulo QUEUE_DEPTH and supports simultaneous push and pop at full.

## Test plan
- Reset, then out_ready=1 with memory word k = 32'hA000_0000+k → out_pc 0,4,8,12…, out_instr A0000000, A0000001, …, one per cycle starting the 2nd cycle after reset release.
- out_ready=0 for 4 cycles from PC 8 → queue holds PCs 8,12; imem_adr stays 16; after release, outputs 8,12,16 back-to-back with no drops or duplicates.
- Queue full, redirect_valid with redirect_pc=64'h20 and out_ready=1 → out_valid=0 next cycle, then out_pc=0x20, 0x24; PCs 8/12 never appear.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC → out_pc FFFF…FFFC, then 0, then 4.
- With IFETCH_ALIGN_CHECK_EN, redirect_pc=64'h22 → fault=1, fault_pc=0x22, out_valid=0, imem_adr frozen; a later redirect to 0x40 clears fault and outputs 0x40. Without the macro, the same stimulus outputs 0x20.
- Assert reset while out_valid=1 and out_ready=0 → out_valid drops immediately (asynchronously); after release, output restarts at RESET_PC.
